// File: rtl/column_pkg.sv
// column_pkg: shared record type, encoder states and W0 field layout
package column_pkg;
    localparam int NUM_COLS_DEFAULT = 640;
    localparam int DIR_BIT = 9;
    localparam int TT_HI = 8;
    localparam int TT_LO = 6;
    localparam int TC_HI = 5;
    localparam int TC_LO = 0;
    typedef struct packed {
        logic [15:0] top;
        logic [15:0] height;
        logic        dir;
        logic [2:0]  tex_type;
        logic [5:0]  tex_col;
        logic [15:0] scale;
        logic        last;
    } col_rec_t;
    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} enc_state_t;
    function automatic logic [15:0] pack_w0(input col_rec_t r);
        logic [15:0] w;
        w = '0;
        w[DIR_BIT] = r.dir;
        w[TT_HI:TT_LO] = r.tex_type;
        w[TC_HI:TC_LO] = r.tex_col;
        return w;
    endfunction
endpackage

// File: rtl/rec_fifo.sv
// rec_fifo: synchronous FIFO of column records with full/empty flags
module rec_fifo
    import column_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  col_rec_t wr_data,
    input  logic     pop,
    output col_rec_t rd_data,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);
    col_rec_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign rd_data = mem[rd_ptr];
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
endmodule

// File: rtl/column_encoder.sv
// column_encoder: serialises buffered column records into four-word Avalon-MM writes
module column_encoder
    import column_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_COLS   = NUM_COLS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_top,
    input  logic [15:0] in_height,
    input  logic        in_dir,
    input  logic [2:0]  in_tex_type,
    input  logic [5:0]  in_tex_col,
    input  logic [15:0] in_scale,
    input  logic        in_last,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic [15:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic        err_clr,
    output logic        frame_done,
    output logic        busy,
    output logic [9:0]  col_count,
    output logic        err_sync
);
    localparam logic [9:0] LAST_COL = 10'(NUM_COLS - 1);
    col_rec_t in_rec, head, hold;
    enc_state_t state;
    logic full, empty, push, pop, accept, last_col, set_err;
    assign in_rec = '{top: in_top, height: in_height, dir: in_dir, tex_type: in_tex_type,
                      tex_col: in_tex_col, scale: in_scale, last: in_last};
    assign in_ready       = !full;
    assign push           = in_valid && !full;
    assign accept         = avm_write && !avm_waitrequest;
    assign pop            = !empty && (state == IDLE || (state == W3 && accept));
    assign last_col       = col_count == LAST_COL;
    assign set_err        = state == W3 && accept && (last_col != hold.last);
    assign busy           = !empty || state != IDLE;
    assign avm_chipselect = avm_write;
    rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(push),
        .wr_data(in_rec),
        .pop(pop),
        .rd_data(head),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            hold          <= '0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            col_count     <= '0;
            frame_done    <= 1'b0;
            err_sync      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_sync   <= set_err || (err_sync && !err_clr);
            case (state)
                IDLE: if (pop) begin
                    hold          <= head;
                    avm_write     <= 1'b1;
                    avm_writedata <= pack_w0(head);
                    state         <= W0;
                end
                W0: if (accept) begin
                    avm_writedata <= hold.height;
                    state         <= W1;
                end
                W1: if (accept) begin
                    avm_writedata <= hold.top;
                    state         <= W2;
                end
                W2: if (accept) begin
                    avm_writedata <= hold.scale;
                    state         <= W3;
                end
                W3: if (accept) begin
                    col_count  <= last_col ? '0 : col_count + 10'd1;
                    frame_done <= last_col;
                    if (pop) begin
                        hold          <= head;
                        avm_writedata <= pack_w0(head);
                        state         <= W0;
                    end else begin
                        avm_write     <= 1'b0;
                        avm_writedata <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_column_encoder.sv
// tb_column_encoder: scoreboard bench for the column record write master
module tb_column_encoder;
    import column_pkg::*;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic err_clr = 1'b0;
    logic avm_waitrequest = 1'b0;
    col_rec_t rec = '0;
    logic in_ready, avm_chipselect, avm_write, frame_done, busy, err_sync;
    logic [15:0] avm_writedata;
    logic [9:0] col_count;
    int n_tests = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];
    int wr_mode = 0;
    int cyc = 0;
    int wcount = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int fd_count = 0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_wd = '0;

    column_encoder #(.FIFO_DEPTH(4), .NUM_COLS(640)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_top(rec.top),
        .in_height(rec.height),
        .in_dir(rec.dir),
        .in_tex_type(rec.tex_type),
        .in_tex_col(rec.tex_col),
        .in_scale(rec.scale),
        .in_last(rec.last),
        .avm_chipselect(avm_chipselect),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .err_clr(err_clr),
        .frame_done(frame_done),
        .busy(busy),
        .col_count(col_count),
        .err_sync(err_sync)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic col_rec_t rand_rec(input logic last);
        col_rec_t r;
        r.top      = 16'($urandom);
        r.height   = 16'($urandom);
        r.dir      = 1'($urandom);
        r.tex_type = 3'($urandom);
        r.tex_col  = 6'($urandom);
        r.scale    = 16'($urandom);
        r.last     = last;
        return r;
    endfunction

    task automatic expect_rec(input col_rec_t r);
        exp_q.push_back({6'b0, r.dir, r.tex_type, r.tex_col});
        exp_q.push_back(r.height);
        exp_q.push_back(r.top);
        exp_q.push_back(r.scale);
    endtask

    task automatic send(input col_rec_t r);
        int n;
        n = 0;
        rec = r;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick;
            n++;
        end
        if (n >= 200) begin
            chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            expect_rec(r);
            tick;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 4000) begin
            tick;
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_write"}, {31'b0, avm_write}, 32'd0);
        chk({tag, "_cs"}, {31'b0, avm_chipselect}, 32'd0);
        chk({tag, "_wd"}, {16'b0, avm_writedata}, 32'd0);
        chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_fd"}, {31'b0, frame_done}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_col"}, {22'b0, col_count}, 32'd0);
        chk({tag, "_err"}, {31'b0, err_sync}, 32'd0);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        exp_q.delete();
        tick;
        tick;
        reset_n = 1'b1;
        tick;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            avm_waitrequest = wr_mode == 1 ? 1'($urandom_range(0, 1)) : (wr_mode == 2);
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_wd", {16'b0, avm_writedata}, {16'b0, prev_wd});
                chk("hold_write", {31'b0, avm_write}, 32'd1);
            end
            if (avm_write && !avm_waitrequest) begin
                chk("cs", {31'b0, avm_chipselect}, 32'd1);
                if (exp_q.size() == 0)
                    chk("extra_word", {16'b0, avm_writedata}, 32'h1_0000);
                else
                    chk("word", {16'b0, avm_writedata}, {16'b0, exp_q.pop_front()});
                if (wcount == 0) first_cyc = cyc;
                last_cyc = cyc;
                wcount++;
            end
            if (frame_done) fd_count++;
            prev_stall = avm_write && avm_waitrequest;
            prev_wd = avm_writedata;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        col_rec_t r;
        int n;
        int acc;
        logic rdy;
        tick;
        tick;
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick;

        r = '{top: 16'h0064, height: 16'h00C8, dir: 1'b1, tex_type: 3'd3,
              tex_col: 6'h2A, scale: 16'h0147, last: 1'b0};
        send(r);
        chk("lat_idle", {31'b0, avm_write}, 32'd0);
        tick;
        chk("single_w0_write", {31'b0, avm_write}, 32'd1);
        chk("single_w0", {16'b0, avm_writedata}, 32'h02EA);
        tick;
        chk("single_w1", {16'b0, avm_writedata}, 32'h00C8);
        tick;
        chk("single_w2", {16'b0, avm_writedata}, 32'h0064);
        tick;
        chk("single_w3", {16'b0, avm_writedata}, 32'h0147);
        tick;
        chk("single_done_write", {31'b0, avm_write}, 32'd0);
        chk("single_col", {22'b0, col_count}, 32'd1);
        chk("single_busy", {31'b0, busy}, 32'd0);

        for (int i = 1; i <= 5; i++) send(rand_rec(i == 5));
        drain;
        chk("err_set", {31'b0, err_sync}, 32'd1);
        chk("err_col", {22'b0, col_count}, 32'd6);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("err_clr", {31'b0, err_sync}, 32'd0);

        r = '{top: 16'hBEEF, height: 16'h1111, dir: 1'b0, tex_type: 3'd5,
              tex_col: 6'h11, scale: 16'h2222, last: 1'b0};
        send(r);
        n = 0;
        while (!(avm_write && avm_writedata == 16'hBEEF) && n < 20) begin
            tick;
            n++;
        end
        chk("reach_w2", {16'b0, avm_writedata}, 32'hBEEF);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        tick;
        reset_n = 1'b1;
        tick;
        send(rand_rec(1'b0));
        chk("post_rst_col0", {22'b0, col_count}, 32'd0);
        drain;
        chk("post_rst_col1", {22'b0, col_count}, 32'd1);

        do_reset;
        wcount = 0;
        fd_count = 0;
        for (int i = 0; i < 640; i++) send(rand_rec(i == 639));
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            tick;
            n++;
        end
        chk("frame_drain", exp_q.size(), 32'd0);
        tick;
        chk("frame_done_pulse", {31'b0, frame_done}, 32'd1);
        chk("frame_col_wrap", {22'b0, col_count}, 32'd0);
        chk("frame_err", {31'b0, err_sync}, 32'd0);
        chk("frame_busy", {31'b0, busy}, 32'd0);
        tick;
        chk("frame_done_end", {31'b0, frame_done}, 32'd0);
        chk("frame_words", wcount, 32'd2560);
        chk("frame_span", last_cyc - first_cyc + 1, 32'd2560);
        chk("frame_pulses", fd_count, 32'd1);

        wr_mode = 1;
        for (int i = 0; i < 8; i++) send(rand_rec(1'b0));
        drain;
        wr_mode = 0;
        chk("rand_col", {22'b0, col_count}, 32'd8);

        wr_mode = 2;
        tick;
        tick;
        acc = 0;
        r = rand_rec(1'b0);
        rec = r;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rdy = in_ready;
            tick;
            if (rdy) begin
                expect_rec(r);
                acc++;
                r = rand_rec(1'b0);
                rec = r;
            end
        end
        chk("stall_accepted", acc, 32'd5);
        chk("stall_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wr_mode = 0;
        drain;
        chk("stall_col", {22'b0, col_count}, 32'd13);
        chk("stall_err", {31'b0, err_sync}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
